cnt_checker: RTL and testbench

Synthesizable monitor for the far end of the cnt interface. It observes a cnt instance's control inputs and count output, predicts each next count value, and flags deviations. It lives beside cnt in system builds and benches for on-chip self-check. It keeps error and coverage counters and resynchronises after every mismatch, so one fault yields exactly one error.

---
 rtl/cnt_checker.sv | 95 +++++++++
 tb/tb_cnt_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_checker.sv
// Runtime monitor for an up/down counter: predicts each next count from the
// observed count and control inputs, and flags and counts any mismatches.
module cnt_checker #(
  parameter int WIDTH     = 4,
  parameter int ERR_WIDTH = 8,
  parameter int CHK_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clr,
  input  logic                 dut_rst,
  input  logic                 en,
  input  logic                 up,
  input  logic                 load,
  input  logic [WIDTH-1:0]     count_in,
  input  logic [WIDTH-1:0]     count,
  output logic [WIDTH-1:0]     expected,
  output logic                 synced,
  output logic                 error,
  output logic                 sticky_err,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [CHK_WIDTH-1:0] chk_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]     CNT_ONE = WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0] ERR_ONE = ERR_WIDTH'(1);
  localparam logic [CHK_WIDTH-1:0] CHK_ONE = CHK_WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pred;
  logic             tracking;
  logic             mismatch;

  // Prediction is taken from the observed count, not from expected, so a
  // single fault re-seeds the model instead of cascading into more errors.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    pred = count;
    if (dut_rst)   pred = '0;
    else if (load) pred = count_in;
    else if (en)   pred = up ? count + CNT_ONE : count - CNT_ONE;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM:     state_nxt = TRACK;
      TRACK:   state_nxt = TRACK;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  assign tracking = (state == TRACK);
  assign mismatch = tracking && !clr && (count != expected);
  assign synced   = tracking;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      expected   <= '0;
      error      <= 1'b0;
      sticky_err <= 1'b0;
      err_count  <= '0;
      chk_count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state    <= state_nxt;
      expected <= pred;
      error    <= mismatch;
      if (clr) begin
        sticky_err <= 1'b0;
        err_count  <= '0;
        chk_count  <= '0;
      end else begin
        if (mismatch) begin
          sticky_err <= 1'b1;
          if (err_count != '1) err_count <= err_count + ERR_ONE;
        end
        if (tracking && chk_count != '1) chk_count <= chk_count + CHK_ONE;
      end
    end
  end

endmodule

// File: tb/tb_cnt_checker.sv
// Self-checking bench for cnt_checker: prediction table, directed corner
// sequences and randomized traffic compared against a behavioural model.
module tb_cnt_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, clr = 1'b0;
  logic       dut_rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [3:0] count_in = '0, count = '0;
  logic [3:0] expected;
  logic       synced, error, sticky_err;
  logic [7:0] err_count;
  logic [15:0] chk_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int         m_since = -1;   // -1 not started, 0 arming, 1 tracking
  logic [3:0] m_exp = '0;
  bit         m_err = 0, m_sticky = 0;
  int         m_errs = 0, m_chks = 0;

  cnt_checker #(.WIDTH(4), .ERR_WIDTH(8), .CHK_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .dut_rst(dut_rst),
    .en(en), .up(up), .load(load), .count_in(count_in), .count(count),
    .expected(expected), .synced(synced), .error(error),
    .sticky_err(sticky_err), .err_count(err_count), .chk_count(chk_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v_dut_rst, v_load, v_en, v_up;
    logic [3:0] v_count_in, v_count, v_exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] cnt_next(input logic [3:0] c);
    int v;
    if (dut_rst)   v = 0;
    else if (load) v = int'(count_in);
    else if (en)   v = up ? (int'(c) + 1) % 16 : (int'(c) + 15) % 16;
    else           v = int'(c);
    return 4'(v);
  endfunction

  task automatic model_reset();
    m_since = -1; m_exp = '0; m_err = 0; m_sticky = 0; m_errs = 0; m_chks = 0;
  endtask

  task automatic model_edge();
    logic [3:0] nx;
    bit trk;
    if (!rst) begin
      model_reset();
      return;
    end
    nx  = cnt_next(count);
    trk = (m_since >= 1);
    if (clr) begin
      m_since = -1; m_err = 0; m_sticky = 0; m_errs = 0; m_chks = 0;
    end else begin
      m_err = trk && (count != m_exp);
      if (trk && m_chks < 65535) m_chks++;
      if (m_err) begin
        m_sticky = 1;
        if (m_errs < 255) m_errs++;
      end
      if (m_since == 0)                m_since = 1;
      else if (m_since < 0 && start)   m_since = 0;
    end
    m_exp = nx;
  endtask

  task automatic check_all();
    check("expected",   expected,   m_exp);
    check("synced",     synced,     (m_since >= 1));
    check("error",      error,      m_err);
    check("sticky_err", sticky_err, m_sticky);
    check("err_count",  err_count,  m_errs);
    check("chk_count",  chk_count,  m_chks);
  endtask

  // One clock: model follows the edge, outputs checked 1ns later, then the
  // monitored counter optionally advances as a healthy cnt would.
  task automatic tick(input bit follow);
    logic [3:0] nx;
    @(posedge clk);
    nx = cnt_next(count);
    model_edge();
    #1;
    check_all();
    if (follow) count = nx;
  endtask

  task automatic go_track();
    clr = 1; start = 0; tick(1);
    clr = 0; start = 1; tick(1);
    start = 0; tick(1);
    check("go_track_synced", synced, 1'b1);
  endtask

  vec_t vecs[8];
  bit   saw_err;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd15, 4'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0,  4'd15};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 4'd3,  4'd7};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 4'd3,  4'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd9,  4'd9};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd4,  4'd5};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd8,  4'd7};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd5,  4'd0};

    // Reset and idle: counter runs, checker never armed
    en = 1; up = 1; count = 0;
    #1 check_all();
    tick(1); tick(1);
    rst = 1;
    repeat (12) tick(1);
    check("idle_chk_count", chk_count, 16'd0);
    check("idle_synced", synced, 1'b0);

    // Prediction table, applied while idle
    for (int i = 0; i < 8; i++) begin
      dut_rst = vecs[i].v_dut_rst; load = vecs[i].v_load;
      en = vecs[i].v_en; up = vecs[i].v_up;
      count_in = vecs[i].v_count_in; count = vecs[i].v_count;
      tick(0);
      check($sformatf("table%0d_expected", i), expected, vecs[i].v_exp);
    end

    // Up count with wrap: 20 cycles, first two are arming
    dut_rst = 0; load = 0; en = 1; up = 1; count = 0; start = 1;
    tick(1);
    start = 0;
    check("wrap_synced_c1", synced, 1'b0);
    tick(1);
    check("wrap_synced_c2", synced, 1'b1);
    repeat (18) tick(1);
    check("wrap_chk_count", chk_count, 16'd18);
    check("wrap_err_count", err_count, 8'd0);

    // Load, count down through zero, then hold
    saw_err = 0;
    load = 1; count_in = 5; en = 0;
    tick(1); saw_err |= error;
    load = 0; en = 1; up = 0;
    repeat (7) begin tick(1); saw_err |= error; end
    en = 0;
    repeat (3) begin tick(1); saw_err |= error; end
    check("down_no_error_pulse", saw_err, 1'b0);
    check("down_count_held", count, 4'd14);

    // Single fault: 9 where 6 is predicted
    go_track();
    load = 1; count_in = 5; en = 0; tick(1);
    load = 0; en = 1; up = 1; tick(0);
    count = 9;
    tick(1);
    check("fault_error_pulse", error, 1'b1);
    check("fault_sticky", sticky_err, 1'b1);
    check("fault_err_count", err_count, 8'd1);
    check("fault_reseeded_expected", expected, 4'd10);
    tick(1);
    check("fault_pulse_ends", error, 1'b0);
    repeat (4) tick(1);
    check("fault_no_cascade", err_count, 8'd1);

    // Priority: dut_rst beats load beats en
    dut_rst = 1; load = 1; count_in = 7; en = 1; up = 1;
    tick(1);
    check("prio_expected_zero", expected, 4'd0);
    dut_rst = 0; load = 0; en = 0;
    tick(1);
    check("prio_zero_accepted", error, 1'b0);
    dut_rst = 1; load = 1; count_in = 7; en = 1;
    tick(0);
    count = 7; dut_rst = 0; load = 0; en = 0;
    tick(1);
    check("prio_seven_flagged", error, 1'b1);

    // Error counter saturation
    go_track();
    for (int i = 0; i < 300; i++) begin
      count = 4'(int'(m_exp) + 1);
      tick(0);
    end
    check("sat_err_count", err_count, 8'd255);
    tick(1);
    check("sat_err_held", err_count, 8'd255);

    // clr wins over start
    clr = 1; start = 1;
    tick(1);
    clr = 0; start = 0;
    check("clr_err_count", err_count, 8'd0);
    check("clr_sticky", sticky_err, 1'b0);
    check("clr_synced", synced, 1'b0);
    tick(1);
    check("clr_stays_idle", synced, 1'b0);

    // Async reset in the middle of tracking
    en = 1; up = 1;
    go_track();
    count = 4'(int'(m_exp) + 3);
    tick(1);
    #2 rst = 0;
    #1 model_reset();
    check_all();
    check("arst_synced", synced, 1'b0);
    check("arst_chk_count", chk_count, 16'd0);
    tick(1);
    rst = 1;
    repeat (3) tick(1);
    check("arst_needs_start", synced, 1'b0);

    // Randomized traffic with occasional faults and control events
    for (int i = 0; i < 600; i++) begin
      dut_rst  = ($urandom_range(99) < 4);
      load     = ($urandom_range(99) < 10);
      en       = ($urandom_range(99) < 70);
      up       = $urandom_range(1);
      count_in = 4'($urandom_range(15));
      start    = ($urandom_range(99) < 6);
      clr      = ($urandom_range(99) < 2);
      tick(1);
      if ($urandom_range(99) < 8) count = 4'($urandom_range(15));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
